// File: rtl/redun_mont_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// redun_mont_pkg
// Shared definitions for the redundant-form Montgomery datapath.
//   WRD_BITS : canonical bits per word; a redundant word is WRD_BITS+1 bits.
//   NUM_WRDS : words per operand, word 0 least significant.
//   redun0_t : one redundant operand, as produced by the squarer's o_mul.
//   bin_t    : one canonical binary operand.
//   ST_*     : state encodings for redun_to_bin.
// -----------------------------------------------------------------------------
package redun_mont_pkg;

  localparam int WRD_BITS = 16;
  localparam int NUM_WRDS = 4;

  typedef logic [WRD_BITS:0]            redun0_t [NUM_WRDS];
  typedef logic [NUM_WRDS*WRD_BITS-1:0] bin_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PROP = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage : redun_mont_pkg

// File: rtl/redun_to_bin.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// redun_to_bin
// Converts a redundant operand (NUM_WRDS words of WRD_BITS+1 bits, the top bit
// of each word overlapping the next word's LSB) into canonical binary by
// rippling the carry through the words, one word per clock.
//
// Ports
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   i_dat   : redundant operand, word 0 least significant
//   i_val   : i_dat valid
//   o_rdy   : operand can be accepted this cycle
//   o_dat   : canonical binary result (unreduced)
//   o_ovf   : nonzero carry out of the top word
//   o_val   : o_dat / o_ovf valid
//   i_rdy   : downstream accepts o_dat
// -----------------------------------------------------------------------------
module redun_to_bin #(
  parameter int WRD_BITS = redun_mont_pkg::WRD_BITS,
  parameter int NUM_WRDS = redun_mont_pkg::NUM_WRDS
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [WRD_BITS:0]            i_dat [NUM_WRDS],
  input  logic                         i_val,
  output logic                         o_rdy,
  output logic [NUM_WRDS*WRD_BITS-1:0] o_dat,
  output logic                         o_ovf,
  output logic                         o_val,
  input  logic                         i_rdy
);

  import redun_mont_pkg::*;

  localparam int CNT_W = (NUM_WRDS > 1) ? $clog2(NUM_WRDS) : 1;
  localparam int OUT_W = NUM_WRDS * WRD_BITS;

  logic [1:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic [1:0]          carry;
  logic [WRD_BITS:0]   words [NUM_WRDS];
  logic [WRD_BITS+1:0] sum;
  logic                accept;
  logic                last_wrd;

  // Ready depends on i_rdy only through o_rdy; o_val/o_dat come straight
  // from registers, so there is no combinational path into the result.
  assign o_rdy    = (state == ST_IDLE) || ((state == ST_DONE) && i_rdy);
  assign accept   = i_val && o_rdy;
  assign o_val    = (state == ST_DONE);
  assign last_wrd = (cnt == CNT_W'(NUM_WRDS - 1));

  // Captured words shift down each PROP cycle, so the single adder always
  // sees the current word at index 0. The worst case is word 2^(W+1)-1 plus
  // carry 2, whose upper two bits are at most 2: the 2-bit carry never clips.
  assign sum = {1'b0, words[0]} + {{WRD_BITS{1'b0}}, carry};

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      carry <= '0;
      o_dat <= '0;
      o_ovf <= 1'b0;
      // NOTE: the capture register is reset too, so nothing of an abandoned
      // operand survives reset; it is small enough that this costs little.
      for (int k = 0; k < NUM_WRDS; k++) begin
        words[k] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            words <= i_dat;
            carry <= '0;
            cnt   <= '0;
            state <= ST_PROP;
          end
        end

        ST_PROP: begin
          // Result slices enter at the top and walk down; after NUM_WRDS
          // cycles word 0's slice sits in the least significant position.
          o_dat <= OUT_W'({sum[WRD_BITS-1:0], o_dat} >> WRD_BITS);
          carry <= sum[WRD_BITS+1:WRD_BITS];
          for (int k = 0; k < NUM_WRDS - 1; k++) begin
            words[k] <= words[k+1];
          end
          words[NUM_WRDS-1] <= '0;
          cnt <= cnt + 1'b1;
          if (last_wrd) begin
            o_ovf <= (sum[WRD_BITS+1:WRD_BITS] != 2'd0);
            state <= ST_DONE;
          end
        end

        ST_DONE: begin
          // Outputs hold until the consumer takes them; a new operand may be
          // captured in the same cycle the old result is consumed.
          if (accept) begin
            words <= i_dat;
            carry <= '0;
            cnt   <= '0;
            state <= ST_PROP;
          end else if (i_rdy) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule : redun_to_bin

// File: tb/tb_redun_to_bin.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_redun_to_bin
// Directed and randomised stimulus for redun_to_bin (WRD_BITS=16, NUM_WRDS=4).
// A reference model computes each result as the plain integer sum of the
// weighted words; a per-cycle monitor compares handshake and data against it,
// and directed cases pin hand-computed literal results.
// -----------------------------------------------------------------------------
module tb_redun_to_bin;

  import redun_mont_pkg::*;

  localparam int W = 16;
  localparam int N = 4;

  typedef struct {
    bin_t dat;
    logic ovf;
    int   t;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W:0]    i_dat [N];
  logic          i_val;
  logic          o_rdy;
  logic [N*W-1:0] o_dat;
  logic          o_ovf;
  logic          o_val;
  logic          i_rdy;

  int   n_vec  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   acc_cyc;
  int   n_push = 0;
  int   last_acc = 0;
  bit   have_acc = 1'b0;
  exp_t q[$];

  redun_to_bin #(.WRD_BITS(W), .NUM_WRDS(N)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_dat   (i_dat),
    .i_val   (i_val),
    .o_rdy   (o_rdy),
    .o_dat   (o_dat),
    .o_ovf   (o_ovf),
    .o_val   (o_val),
    .i_rdy   (i_rdy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: value = sum of word[k] * 2^(16k); the low 64 bits are the
  // result and anything above them is overflow.
  function automatic exp_t model(input logic [W:0] w [N], input int t);
    logic [67:0] s;
    exp_t e;
    s = '0;
    for (int k = 0; k < N; k++) s = s + (68'(w[k]) << (W * k));
    e.dat = s[N*W-1:0];
    e.ovf = |s[67:N*W];
    e.t   = t;
    return e;
  endfunction

  // Per-cycle monitor, sampled on the falling edge.
  always @(negedge clk) begin
    bit ev, er;
    if (!rst_n) begin
      q.delete();
      have_acc = 1'b0;
      check("rst_o_val", o_val, 0);
      check("rst_o_dat", o_dat, 0);
    end else begin
      ev = (q.size() > 0) && (cyc >= q[0].t + N + 1);
      er = !(have_acc && (cyc <= last_acc + N)) && (!ev || i_rdy);
      check("o_val", o_val, ev);
      check("o_rdy", o_rdy, er);
      if (ev) begin
        check("o_dat", o_dat, q[0].dat);
        check("o_ovf", o_ovf, q[0].ovf);
        if (i_rdy) void'(q.pop_front());
      end
      if (er && i_val) begin
        q.push_back(model(i_dat, cyc));
        have_acc = 1'b1;
        last_acc = cyc;
        n_push++;
      end
    end
  end

  task automatic apply(input logic [W:0] w [N]);
    bit got;
    got   = 1'b0;
    i_dat = w;
    i_val = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (o_rdy) begin
        got     = 1'b1;
        acc_cyc = cyc;
        break;
      end
    end
    if (!got) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    i_val = 1'b0;
  endtask

  task automatic wait_val(output int lat);
    lat = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (o_val) begin
        lat = cyc - acc_cyc;
        break;
      end
    end
    if (lat < 0) check("o_val_timeout", 0, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [W:0] w [N];
    logic [W:0] wb [N];
    int lat;
    int start;

    rst_n = 1'b0;
    i_val = 1'b0;
    i_rdy = 1'b1;
    for (int k = 0; k < N; k++) i_dat[k] = '0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("rdy_after_rst", o_rdy, 1);
    check("val_after_rst", o_val, 0);
    check("ovf_after_rst", o_ovf, 0);
    check("dat_after_rst", o_dat, 0);
    @(posedge clk); #1;

    // All words 0x0FFFF: no carries at all.
    w = '{17'h0FFFF, 17'h0FFFF, 17'h0FFFF, 17'h0FFFF};
    apply(w);
    wait_val(lat);
    check("lat_0ffff", lat, 5);
    check("dat_0ffff", o_dat, 64'hFFFF_FFFF_FFFF_FFFF);
    check("ovf_0ffff", o_ovf, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_after_take", o_val, 0);
    @(posedge clk); #1;

    // All words 0x1FFFF: carry reaches 2 from word 1 upward, so the result
    // is 0x2_0001_0001_0000_FFFF, not all-ones.
    w = '{17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF};
    apply(w);
    wait_val(lat);
    check("lat_1ffff", lat, 5);
    check("dat_1ffff", o_dat, 64'h0001_0001_0000_FFFF);
    check("ovf_1ffff", o_ovf, 1);
    @(posedge clk); #1;

    // Only the overlap bit of word 0 set.
    w = '{17'h10000, 17'h00000, 17'h00000, 17'h00000};
    apply(w);
    wait_val(lat);
    check("dat_w0_top", o_dat, 64'h0000_0000_0001_0000);
    check("ovf_w0_top", o_ovf, 0);
    @(posedge clk); #1;

    // Back-pressure: result held for 10 cycles while i_val pulses.
    i_rdy = 1'b0;
    w  = '{17'h0ABCD, 17'h11234, 17'h00001, 17'h1FFFF};
    wb = '{17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF};
    apply(w);
    wait_val(lat);
    check("lat_bp", lat, 5);
    check("dat_bp", o_dat, 64'hFFFF_0002_1234_ABCD);
    check("ovf_bp", o_ovf, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      i_dat = wb;
      i_val = i[0];
      @(negedge clk);
      check("hold_val", o_val, 1);
      check("hold_dat", o_dat, 64'hFFFF_0002_1234_ABCD);
      check("hold_ovf", o_ovf, 1);
      check("hold_rdy", o_rdy, 0);
    end
    // Release with a new operand in the same cycle.
    @(posedge clk); #1;
    i_dat = '{17'h00005, 17'h10000, 17'h00000, 17'h0FFFF};
    i_val = 1'b1;
    i_rdy = 1'b1;
    @(negedge clk);
    check("b2b_rdy", o_rdy, 1);
    acc_cyc = cyc;
    @(posedge clk); #1;
    i_val = 1'b0;
    wait_val(lat);
    check("lat_b2b", lat, 5);
    check("dat_b2b", o_dat, 64'hFFFF_0001_0000_0005);
    check("ovf_b2b", o_ovf, 0);
    @(posedge clk); #1;

    // Reset in the second PROP cycle abandons the operand.
    w = '{17'h12345, 17'h0F0F0, 17'h1AAAA, 17'h05555};
    apply(w);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_val", o_val, 0);
    check("midrst_rdy", o_rdy, 1);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_rdy", o_rdy, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("no_stale_val", o_val, 0);
    end
    @(posedge clk); #1;

    // Random traffic; the monitor checks every cycle.
    start = n_push;
    for (int c = 0; c < 40000 && (n_push - start) < 2000; c++) begin
      i_val = 1'($urandom_range(0, 1));
      i_rdy = ($urandom_range(0, 9) < 7);
      for (int k = 0; k < N; k++)
        i_dat[k] = ($urandom_range(0, 3) == 0) ? 17'h1FFFF : 17'($urandom_range(0, 17'h1FFFF));
      @(posedge clk); #1;
    end
    check("rand_count", (n_push - start) >= 2000, 1);
    i_val = 1'b0;
    i_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (q.size() == 0) break;
    end
    check("drain", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_redun_to_bin
